// File: rtl/store_retire_buffer.sv
// store_retire_buffer: circular FIFO receiving up to N_WAY committed stores per
// cycle and draining them one at a time to the D-cache write port.
//
// Ports:
//   clock, reset          clock; synchronous active-high reset
//   ret_valid/addr/data   per-lane retired stores (lane 0 oldest)
//   free_slots            min(DEPTH-count, N_WAY) from registered count
//   mem_cmd_*             head-entry write command, valid/ready handshake
//   mem_done              completion of the accepted write
//   ld_valid/addr         forwarding lookup
//   ld_hit/ld_data        youngest buffered store matching ld_addr
//   drained               empty and idle
//   overflow_err          sticky: a push was dropped for lack of space
module store_retire_buffer #(
    parameter int N_WAY  = 2,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_WAY-1:0]        ret_valid,
    input  logic [N_WAY*ADDR_W-1:0] ret_addr,
    input  logic [N_WAY*DATA_W-1:0] ret_data,
    output logic [$clog2(N_WAY):0]  free_slots,
    output logic                    mem_cmd_valid,
    output logic [ADDR_W-1:0]       mem_cmd_addr,
    output logic [DATA_W-1:0]       mem_cmd_data,
    input  logic                    mem_cmd_ready,
    input  logic                    mem_done,
    input  logic                    ld_valid,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_hit,
    output logic [DATA_W-1:0]       ld_data,
    output logic                    drained,
    output logic                    overflow_err
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int CW = $clog2(N_WAY) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t state_q, state_d;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic          pop;
    logic [PW-1:0] room;
    logic [PW-1:0] n_push;
    logic          drop;
    logic          lane_we  [N_WAY];
    logic [IW-1:0] lane_idx [N_WAY];

    // Head leaves only when its write completes.
    assign pop = (state_q == S_WAIT) && mem_done;

    // Room is measured after this cycle's pop; valid lanes are packed
    // into consecutive slots starting at tail, excess lanes are dropped.
    always_comb begin
        room   = PW'(DEPTH) - (count_q - {{(PW-1){1'b0}}, pop});
        n_push = '0;
        drop   = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            lane_we[i]  = 1'b0;
            lane_idx[i] = '0;
            if (ret_valid[i]) begin
                if (n_push < room) begin
                    lane_we[i]  = 1'b1;
                    lane_idx[i] = tail_q[IW-1:0] + n_push[IW-1:0];
                    n_push      = n_push + PW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        head_d     = head_q + {{(PW-1){1'b0}}, pop};
        tail_d     = tail_q + n_push;
        count_d    = count_q - {{(PW-1){1'b0}}, pop} + n_push;
        overflow_d = overflow_q | drop;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_WAY; i++) begin
            if (lane_we[i]) begin
                addr_q[lane_idx[i]] <= ret_addr[i*ADDR_W +: ADDR_W];
                data_q[lane_idx[i]] <= ret_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_cmd_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    state_d = (count_q > PW'(1)) ? S_ISSUE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_cmd_valid = (state_q == S_ISSUE);
        mem_cmd_addr  = '0;
        mem_cmd_data  = '0;
        if (mem_cmd_valid) begin
            mem_cmd_addr = addr_q[head_q[IW-1:0]];
            mem_cmd_data = data_q[head_q[IW-1:0]];
        end
        drained = (count_q == '0) && (state_q == S_IDLE);
    end

    logic [PW-1:0] avail;

    always_comb begin
        avail = PW'(DEPTH) - count_q;
        if (avail > PW'(N_WAY)) begin
            free_slots = CW'(N_WAY);
        end else begin
            free_slots = CW'(avail);
        end
    end

    assign overflow_err = overflow_q;

    // Walk oldest to youngest so the last match is the youngest store.
    logic [IW-1:0] fidx;

    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fidx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = head_q[IW-1:0] + IW'(k);
            if (ld_valid && (PW'(k) < count_q) &&
                (addr_q[fidx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = data_q[fidx];
            end
        end
    end

endmodule

// File: tb/tb_store_retire_buffer.sv
// Directed bench for store_retire_buffer with a queue-based reference
// model compared against the DUT every cycle.
module tb_store_retire_buffer;

    localparam int NW = 2;
    localparam int DP = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic [1:0]    ret_valid;
    logic [63:0]   ret_addr;
    logic [127:0]  ret_data;
    logic [1:0]    free_slots;
    logic          mem_cmd_valid;
    logic [31:0]   mem_cmd_addr;
    logic [63:0]   mem_cmd_data;
    logic          mem_cmd_ready;
    logic          mem_done;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hit;
    logic [63:0]   ld_data;
    logic          drained;
    logic          overflow_err;

    always #5 clock = ~clock;

    store_retire_buffer #(
        .N_WAY(NW), .DEPTH(DP), .ADDR_W(32), .DATA_W(64)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ret_valid    (ret_valid),
        .ret_addr     (ret_addr),
        .ret_data     (ret_data),
        .free_slots   (free_slots),
        .mem_cmd_valid(mem_cmd_valid),
        .mem_cmd_addr (mem_cmd_addr),
        .mem_cmd_data (mem_cmd_data),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_done     (mem_done),
        .ld_valid     (ld_valid),
        .ld_addr      (ld_addr),
        .ld_hit       (ld_hit),
        .ld_data      (ld_data),
        .drained      (drained),
        .overflow_err (overflow_err)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } ent_t;

    typedef enum {P_IDLE, P_ISSUE, P_WAIT} ph_t;

    ent_t mq[$];
    ph_t  mph = P_IDLE;
    bit   movf = 0;

    always @(posedge clock) begin
        bit pop;
        int sz;
        ent_t e;
        if (reset) begin
            mq.delete();
            mph  = P_IDLE;
            movf = 0;
        end else begin
            sz  = mq.size();
            pop = (mph == P_WAIT) && mem_done;
            case (mph)
                P_IDLE:  if (sz > 0) mph = P_ISSUE;
                P_ISSUE: if (mem_cmd_ready) mph = P_WAIT;
                P_WAIT:  if (mem_done) mph = (sz > 1) ? P_ISSUE : P_IDLE;
                default: mph = P_IDLE;
            endcase
            if (pop) void'(mq.pop_front());
            for (int i = 0; i < NW; i++) begin
                if (ret_valid[i]) begin
                    if (mq.size() < DP) begin
                        e.a = ret_addr[i*32 +: 32];
                        e.d = ret_data[i*64 +: 64];
                        mq.push_back(e);
                    end else begin
                        movf = 1;
                    end
                end
            end
        end
    end

    function automatic int mfree();
        int f;
        f = DP - mq.size();
        return (f > NW) ? NW : f;
    endfunction

    // Every-cycle comparison against the model, plus write-order log.
    ent_t wlog[$];

    always @(negedge clock) begin
        logic        xv;
        logic [31:0] xa;
        logic [63:0] xd;
        logic        xh;
        logic [63:0] xl;
        if (chk_en) begin
            xv = (mph == P_ISSUE);
            xa = (xv && mq.size() > 0) ? mq[0].a : 32'h0;
            xd = (xv && mq.size() > 0) ? mq[0].d : 64'h0;
            xh = 1'b0;
            xl = 64'h0;
            if (ld_valid) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (!xh && mq[i].a == ld_addr) begin
                        xh = 1'b1;
                        xl = mq[i].d;
                    end
                end
            end
            chk("cmd_valid", 64'(mem_cmd_valid), 64'(xv));
            chk("cmd_addr", 64'(mem_cmd_addr), 64'(xa));
            chk("cmd_data", mem_cmd_data, xd);
            chk("free_slots", 64'(free_slots), 64'(mfree()));
            chk("drained", 64'(drained),
                64'(mq.size() == 0 && mph == P_IDLE));
            chk("overflow", 64'(overflow_err), 64'(movf));
            chk("ld_hit", 64'(ld_hit), 64'(xh));
            chk("ld_data", ld_data, xl);
            if (!reset && mem_cmd_valid && mem_cmd_ready) begin
                wlog.push_back('{a: mem_cmd_addr, d: mem_cmd_data});
            end
        end
    end

    // ---------------- memory responder ----------------
    bit resp_en = 0;
    bit rnd     = 0;
    int rdy_dly = 0;
    int done_dly = 0;
    int rcnt = 0;
    int dcnt = 0;
    bit waiting = 0;

    always @(posedge clock) begin
        #1;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;
        if (reset || !resp_en) begin
            waiting = 0;
            rcnt    = rnd ? $urandom_range(0, 3) : rdy_dly;
        end else if (!waiting) begin
            if (mem_cmd_valid) begin
                if (rcnt == 0) begin
                    mem_cmd_ready = 1'b1;
                    waiting = 1;
                    dcnt = rnd ? $urandom_range(0, 3) : done_dly;
                end else begin
                    rcnt--;
                end
            end
        end else begin
            if (dcnt == 0) begin
                mem_done = 1'b1;
                waiting  = 0;
                rcnt = rnd ? $urandom_range(0, 3) : rdy_dly;
            end else begin
                dcnt--;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [1:0] m,
                        input logic [31:0] a0, input logic [63:0] d0,
                        input logic [31:0] a1, input logic [63:0] d1);
        ret_valid = m;
        ret_addr  = {a1, a0};
        ret_data  = {d1, d0};
        tick();
        ret_valid = 2'b00;
    endtask

    task automatic wait_drained(input string nm, input int budget);
        int n = 0;
        while (!drained && n < budget) begin
            tick();
            n++;
        end
        chk(nm, 64'(drained), 64'd1);
    endtask

    ent_t exp_q[$];

    initial begin
        int sent;
        int guard;
        int n;
        int nf;
        logic [1:0] m;
        ent_t e;

        reset     = 1'b1;
        ret_valid = '0;
        ret_addr  = '0;
        ret_data  = '0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        mem_cmd_ready = 1'b0;
        mem_done      = 1'b0;

        // 1: reset state
        tick();
        chk_en = 1;
        tick();
        chk("t1_free", 64'(free_slots), 64'd2);
        chk("t1_drained", 64'(drained), 64'd1);
        chk("t1_cmd_valid", 64'(mem_cmd_valid), 64'd0);
        chk("t1_ovf", 64'(overflow_err), 64'd0);
        reset = 1'b0;
        tick();

        // 2: two-lane push drains in order
        resp_en  = 1;
        rdy_dly  = 0;
        done_dly = 1;
        wlog.delete();
        push(2'b11, 32'h100, 64'hA, 32'h104, 64'hB);
        wait_drained("t2_drain", 50);
        chk("t2_nwr", 64'(wlog.size()), 64'd2);
        chk("t2_a0", 64'(wlog[0].a), 64'h100);
        chk("t2_d0", wlog[0].d, 64'hA);
        chk("t2_a1", 64'(wlog[1].a), 64'h104);
        chk("t2_d1", wlog[1].d, 64'hB);

        // 3: fill with memory stalled, then overflow
        resp_en = 0;
        tick();
        wlog.delete();
        for (int c = 0; c < 4; c++) begin
            chk("t3_free", 64'(free_slots), 64'd2);
            push(2'b11, 32'h500 + 32'(8*c), 64'(2*c),
                 32'h504 + 32'(8*c), 64'(2*c + 1));
        end
        chk("t3_free_full", 64'(free_slots), 64'd0);
        chk("t3_ovf_pre", 64'(overflow_err), 64'd0);
        push(2'b11, 32'h5F0, 64'hEE, 32'h5F4, 64'hFF);
        chk("t3_ovf", 64'(overflow_err), 64'd1);
        chk("t3_free_after", 64'(free_slots), 64'd0);
        chk("t3_head_addr", 64'(mem_cmd_addr), 64'h500);
        chk("t3_head_data", mem_cmd_data, 64'h0);
        resp_en = 1;
        wait_drained("t3_drain", 200);
        chk("t3_nwr", 64'(wlog.size()), 64'd8);
        chk("t3_last", 64'(wlog[7].a), 64'h51C);

        // 4: forwarding picks youngest store
        resp_en = 0;
        tick();
        push(2'b01, 32'h200, 64'd1, 32'h0, 64'h0);
        push(2'b01, 32'h200, 64'd2, 32'h0, 64'h0);
        ld_valid = 1'b1;
        ld_addr  = 32'h200;
        #1;
        chk("t4_hit", 64'(ld_hit), 64'd1);
        chk("t4_data", ld_data, 64'd2);
        ld_valid = 1'b0;
        #1;
        chk("t4_noval", 64'(ld_hit), 64'd0);
        ld_valid = 1'b1;
        resp_en  = 1;
        wait_drained("t4_drain", 100);
        chk("t4_hit_gone", 64'(ld_hit), 64'd0);
        chk("t4_data_gone", ld_data, 64'd0);
        ld_valid = 1'b0;

        // 5: lane-1-only push compacts into one entry
        resp_en = 0;
        tick();
        push(2'b10, 32'hDEAD, 64'hBAD, 32'h300, 64'h33);
        tick();
        chk("t5_valid", 64'(mem_cmd_valid), 64'd1);
        chk("t5_addr", 64'(mem_cmd_addr), 64'h300);
        chk("t5_data", mem_cmd_data, 64'h33);
        chk("t5_free", 64'(free_slots), 64'd2);
        resp_en = 1;
        wait_drained("t5_drain", 50);

        // 6: 12 stores with random handshake delays across wrap
        rnd = 1;
        wlog.delete();
        exp_q.delete();
        sent  = 0;
        guard = 0;
        while (sent < 12 && guard < 400) begin
            nf = mfree();
            n  = $urandom_range(0, 2);
            if (n > nf) n = nf;
            if (n > 12 - sent) n = 12 - sent;
            if (n == 2) m = 2'b11;
            else if (n == 1) m = $urandom_range(0, 1) ? 2'b01 : 2'b10;
            else m = 2'b00;
            ret_addr = {32'h800 + 32'(4*(sent+1)), 32'h800 + 32'(4*sent)};
            ret_data = {64'h1111 * 64'(sent + 2), 64'h1111 * 64'(sent + 1)};
            if (m == 2'b11) begin
                exp_q.push_back('{a: 32'h800 + 32'(4*sent),
                                  d: 64'h1111 * 64'(sent + 1)});
                exp_q.push_back('{a: 32'h800 + 32'(4*(sent+1)),
                                  d: 64'h1111 * 64'(sent + 2)});
            end else if (m == 2'b01) begin
                exp_q.push_back('{a: 32'h800 + 32'(4*sent),
                                  d: 64'h1111 * 64'(sent + 1)});
            end else if (m == 2'b10) begin
                exp_q.push_back('{a: 32'h800 + 32'(4*(sent+1)),
                                  d: 64'h1111 * 64'(sent + 2)});
            end
            sent += n;
            ret_valid = m;
            tick();
            ret_valid = 2'b00;
            guard++;
        end
        chk("t6_sent", 64'(sent), 64'd12);
        wait_drained("t6_drain", 300);
        chk("t6_nwr", 64'(wlog.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            e = (i < exp_q.size()) ? exp_q[i] : '{a: 32'hX, d: 64'hX};
            chk($sformatf("t6_a%0d", i), 64'(wlog[i].a), 64'(e.a));
            chk($sformatf("t6_d%0d", i), wlog[i].d, e.d);
        end

        // 6b: reset while waiting on mem_done
        rnd      = 0;
        rdy_dly  = 0;
        done_dly = 50;
        push(2'b01, 32'h900, 64'h99, 32'h0, 64'h0);
        guard = 0;
        while (mph != P_WAIT && guard < 20) begin
            tick();
            guard++;
        end
        chk("t6_reached_wait", 64'(mem_cmd_valid), 64'd0);
        chk("t6_busy", 64'(drained), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", 64'(mem_cmd_valid), 64'd0);
        chk("t6_rst_drained", 64'(drained), 64'd1);
        chk("t6_rst_free", 64'(free_slots), 64'd2);
        chk("t6_rst_ovf", 64'(overflow_err), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        chk("t6_post_drained", 64'(drained), 64'd1);
        chk("t6_post_valid", 64'(mem_cmd_valid), 64'd0);

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
